// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, bit-cell phases and sequence lengths.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    SEND_BIT = 3'd2,
    GET_ACK  = 3'd3,
    STOP     = 3'd4
  } i2c_state_e;

  localparam logic [1:0] PH_SETUP  = 2'd0;
  localparam logic [1:0] PH_LOW    = 2'd1;
  localparam logic [1:0] PH_HIGH   = 2'd2;
  localparam logic [1:0] PH_SAMPLE = 2'd3;

  localparam logic I2C_WRITE_BIT = 1'b0;

  localparam int unsigned START_QUARTERS = 3;
  localparam int unsigned STOP_QUARTERS  = 3;
  localparam int unsigned BIT_QUARTERS   = 4;

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period timer: tick on the last cycle of each quarter, pre_tick one cycle earlier.
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // clear parks the counter so the next quarter starts a full CLK_DIV later
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      tick     <= 1'b0;
      pre_tick <= 1'b0;
    end else if (clear) begin
      cnt      <= RELOAD;
      tick     <= 1'b0;
      pre_tick <= 1'b0;
    end else begin
      cnt      <= (cnt == '0) ? RELOAD : cnt - CNT_W'(1);
      tick     <= (cnt == CNT_W'(1));
      pre_tick <= (cnt == CNT_W'(2));
    end
  end

endmodule

// File: rtl/i2c_master_writer.sv
// Write-only single-master I2C engine: START, address+W, 0..8 payload bytes with ACK checks, STOP.
module i2c_master_writer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 125,
  parameter int unsigned MAX_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  addr,
  input  logic [63:0] data,
  input  logic [3:0]  num_bytes,
  output logic        busy,
  output logic        done,
  output logic        nack_err,
  output logic        scl,
  inout  wire         sda
);

  localparam logic [3:0] MAX_N      = 4'(MAX_BYTES);
  localparam logic [1:0] START_LAST = 2'(START_QUARTERS - 1);
  localparam logic [1:0] STOP_LAST  = 2'(STOP_QUARTERS - 1);
  localparam logic [1:0] BIT_LAST   = 2'(BIT_QUARTERS - 1);

  i2c_state_e  state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [3:0]  bytes_left_q, bytes_left_d;
  logic [7:0]  cur_byte_q, cur_byte_d;
  logic [63:0] data_q, data_d;
  logic        busy_d, done_d, nack_d, scl_d, sda_low_d;
  logic        sda_low;
  logic [1:0]  sync_q;
  logic [2:0]  byte_sel;
  logic        tick, pre_tick, qt_clear;

  assign sda      = sda_low ? 1'b0 : 1'bz;
  assign byte_sel = 3'(bytes_left_q - 4'd1);
  assign qt_clear = (state_q == IDLE);

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk      (clk),
    .rst      (rst),
    .clear    (qt_clear),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ph_q         <= PH_SETUP;
      bit_idx_q    <= '0;
      bytes_left_q <= '0;
      cur_byte_q   <= '0;
      data_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      nack_err     <= 1'b0;
      scl          <= 1'b1;
      sda_low      <= 1'b0;
      sync_q       <= 2'b11;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      bit_idx_q    <= bit_idx_d;
      bytes_left_q <= bytes_left_d;
      cur_byte_q   <= cur_byte_d;
      data_q       <= data_d;
      busy         <= busy_d;
      done         <= done_d;
      nack_err     <= nack_d;
      scl          <= scl_d;
      sda_low      <= sda_low_d;
      sync_q       <= {sync_q[0], sda};
    end
  end

  // Sequencing advances on quarter ticks; bus levels are then decoded for the upcoming quarter.
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    bit_idx_d    = bit_idx_q;
    bytes_left_d = bytes_left_q;
    cur_byte_d   = cur_byte_q;
    data_d       = data_q;
    busy_d       = busy;
    done_d       = 1'b0;
    nack_d       = nack_err;
    scl_d        = 1'b1;
    sda_low_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = START;
          ph_d         = PH_SETUP;
          cur_byte_d   = {addr, I2C_WRITE_BIT};
          data_d       = data;
          bytes_left_d = (num_bytes > MAX_N) ? MAX_N : num_bytes;
          busy_d       = 1'b1;
          nack_d       = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (ph_q == START_LAST) begin
            state_d   = SEND_BIT;
            ph_d      = PH_SETUP;
            bit_idx_d = 3'd7;
          end else begin
            ph_d = ph_q + 2'd1;
          end
        end
      end
      SEND_BIT: begin
        if (tick) begin
          if (ph_q == BIT_LAST) begin
            ph_d = PH_SETUP;
            if (bit_idx_q == 3'd0) state_d = GET_ACK;
            else bit_idx_d = bit_idx_q - 3'd1;
          end else begin
            ph_d = ph_q + 2'd1;
          end
        end
      end
      GET_ACK: begin
        if (tick) begin
          if (ph_q == BIT_LAST) begin
            ph_d = PH_SETUP;
            if (sync_q[1]) begin
              state_d = STOP;
              nack_d  = 1'b1;
            end else if (bytes_left_q == 4'd0) begin
              state_d = STOP;
            end else begin
              state_d      = SEND_BIT;
              bit_idx_d    = 3'd7;
              cur_byte_d   = data_q[{byte_sel, 3'b000} +: 8];
              bytes_left_d = bytes_left_q - 4'd1;
            end
          end else begin
            ph_d = ph_q + 2'd1;
          end
        end
      end
      STOP: begin
        // done/busy are registered, so they are launched one cycle before the final tick
        if (pre_tick && ph_q == STOP_LAST) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        if (tick) begin
          if (ph_q == STOP_LAST) begin
            state_d = IDLE;
            ph_d    = PH_SETUP;
          end else begin
            ph_d = ph_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START: begin
        scl_d     = (ph_d != START_LAST);
        sda_low_d = (ph_d != PH_SETUP);
      end
      SEND_BIT: begin
        scl_d     = !(ph_d == PH_SETUP || ph_d == PH_LOW);
        sda_low_d = !cur_byte_d[bit_idx_d];
      end
      GET_ACK: begin
        scl_d     = (ph_d == PH_HIGH || ph_d == PH_SAMPLE);
      end
      STOP: begin
        scl_d     = (ph_d != PH_SETUP);
        sda_low_d = (ph_d != STOP_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_writer.sv
// Randomized scoreboard bench for i2c_master_writer with a behavioural bus slave and protocol monitor.
module tb_i2c_master_writer;

  localparam int unsigned D = 8;
  localparam logic [6:0] SLAVE_ADDR = 7'h6A;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [6:0]  addr;
  logic [63:0] data;
  logic [3:0]  num_bytes;
  logic        busy, done, nack_err, scl;
  wire         sda;
  logic        slave_low = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_master_writer #(.CLK_DIV(D), .MAX_BYTES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .data(data),
    .num_bytes(num_bytes), .busy(busy), .done(done), .nack_err(nack_err),
    .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    longint t_done;
    bit     nack;
    int     n_rx;
    int     n_bus;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] rx_q[$];
  int         done_cnt = 0;

  // Behavioural slave at SLAVE_ADDR plus START/STOP/SCL-timing observer
  logic       p_scl = 1'b1, p_sda = 1'b1, active = 1'b0, in_ack = 1'b0, selected = 1'b0;
  logic       skip_high = 1'b0, first_low = 1'b0, pend_valid = 1'b0;
  logic [7:0] sh = '0;
  int         bitcnt = 0, byte_no = 0, run = 0, pend_low = 0;
  int         starts_tot = 0, stops_tot = 0, bytes_tot = 0, tim_bad = 0;

  always @(posedge clk) begin
    p_scl <= scl;
    p_sda <= sda;
    run   <= (scl != p_scl) ? 1 : run + 1;
    if (rst) begin
      active     <= 1'b0;
      in_ack     <= 1'b0;
      slave_low  <= 1'b0;
      pend_valid <= 1'b0;
    end else if (p_scl && scl && p_sda && !sda) begin
      starts_tot <= starts_tot + 1;
      active     <= 1'b1;
      bitcnt     <= 0;
      byte_no    <= 0;
      in_ack     <= 1'b0;
      skip_high  <= 1'b1;
      first_low  <= 1'b1;
      pend_valid <= 1'b0;
    end else if (p_scl && scl && !p_sda && sda) begin
      stops_tot  <= stops_tot + 1;
      active     <= 1'b0;
      slave_low  <= 1'b0;
      pend_valid <= 1'b0;
    end else if (active && !p_scl && scl) begin
      if (!in_ack) begin
        sh     <= {sh[6:0], sda};
        bitcnt <= bitcnt + 1;
      end
      if (!first_low) begin
        pend_low   <= run;
        pend_valid <= 1'b1;
      end
      first_low <= 1'b0;
    end else if (active && p_scl && !scl) begin
      tim_bad <= tim_bad + ((!skip_high && run != 2 * D) ? 1 : 0)
                         + ((pend_valid && pend_low != 2 * D) ? 1 : 0);
      skip_high  <= 1'b0;
      pend_valid <= 1'b0;
      if (in_ack) begin
        in_ack    <= 1'b0;
        slave_low <= 1'b0;
      end else if (bitcnt == 8) begin
        bytes_tot <= bytes_tot + 1;
        if (byte_no != 0 && selected) rx_q.push_back(sh);
        selected  <= (byte_no == 0) ? (sh == {SLAVE_ADDR, 1'b0}) : selected;
        slave_low <= (byte_no == 0) ? (sh == {SLAVE_ADDR, 1'b0}) : selected;
        in_ack    <= 1'b1;
        bitcnt    <= 0;
        byte_no   <= byte_no + 1;
      end
    end
  end

  // Scoreboard monitor: pops one expectation per done pulse
  initial begin
    exp_t       e;
    logic [7:0] b;
    int         s_starts = 0, s_stops = 0, s_bytes = 0, s_bad = 0, rx_rd = 0, rx_before;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_starts = starts_tot; s_stops = stops_tot; s_bytes = bytes_tot; s_bad = tim_bad;
        rx_rd = rx_q.size();
      end else if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.t_done);
          check("nack_err", nack_err, e.nack);
          check("busy_at_done", busy, 0);
          check("bus_bytes", bytes_tot - s_bytes, e.n_bus);
          check("starts", starts_tot - s_starts, 1);
          check("stops", stops_tot - s_stops, 1);
          check("scl_timing_violations", tim_bad - s_bad, 0);
          rx_before = rx_q.size() - rx_rd;
          check("rx_count", rx_before, e.n_rx);
          for (int i = 0; i < e.n_rx; i++) begin
            b = exp_bytes.pop_front();
            if (rx_rd < rx_q.size()) begin
              check("rx_byte", rx_q[rx_rd], b);
              rx_rd++;
            end
          end
        end
        s_starts = starts_tot; s_stops = stops_tot; s_bytes = bytes_tot; s_bad = tim_bad;
        rx_rd = rx_q.size();
      end
    end
  end

  function automatic int eff_n(input logic [3:0] nb);
    return (nb > 4'd8) ? 8 : int'(nb);
  endfunction

  task automatic issue(input logic [6:0] a, input logic [63:0] d, input logic [3:0] nb,
                       input bit disturb);
    exp_t e;
    int   n, q, seen;
    bit   ack;
    n   = eff_n(nb);
    ack = (a == SLAVE_ADDR);
    q   = ack ? 6 + 36 * (n + 1) : 42;
    @(posedge clk); #1;
    addr = a; data = d; num_bytes = nb; start = 1'b1;
    e.t_done = cyc + longint'(q * D);
    e.nack   = !ack;
    e.n_rx   = ack ? n : 0;
    e.n_bus  = ack ? n + 1 : 1;
    exp_q.push_back(e);
    if (ack) for (int j = n - 1; j >= 0; j--) exp_bytes.push_back(d[8*j +: 8]);
    seen = done_cnt;
    @(posedge clk); #1;
    start = 1'b0; addr = 7'($urandom); data = {$urandom, $urandom}; num_bytes = 4'($urandom);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("nack_cleared", nack_err, 0);
    if (disturb) begin
      repeat (q * D / 2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < q * int'(D) + 50 && done_cnt == seen; i++) @(posedge clk);
    check("done_seen", longint'(done_cnt != seen), 1);
    if (done_cnt == seen) begin
      exp_q.delete();
      exp_bytes.delete();
    end else begin
      @(negedge clk);
      check("done_pulse_width", done, 0);
      check("nack_hold", nack_err, !ack);
      check("idle_after_done", busy, 0);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_mid_byte();
    @(posedge clk); #1;
    addr = SLAVE_ADDR; data = {$urandom, $urandom}; num_bytes = 4'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (48 * D + D / 2 - 1) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_mid_scl", scl, 1);
    check("rst_mid_sda", sda, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_nack", nack_err, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; addr = '0; data = '0; num_bytes = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_scl", scl, 1);
    check("reset_sda", sda, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_nack", nack_err, 0);
    @(posedge clk); #1 rst = 1'b0;

    issue(SLAVE_ADDR, 64'hDEADBEEFCAFEBABE, 4'd8, 1'b0);
    issue(SLAVE_ADDR, 64'h000000000000FACE, 4'd2, 1'b0);
    issue(7'h11, {$urandom, $urandom}, 4'd5, 1'b0);
    issue(SLAVE_ADDR, {$urandom, $urandom}, 4'd0, 1'b0);
    issue(SLAVE_ADDR, {$urandom, $urandom}, 4'd12, 1'b0);
    issue(SLAVE_ADDR, {$urandom, $urandom}, 4'd3, 1'b1);
    reset_mid_byte();
    issue(SLAVE_ADDR, {$urandom, $urandom}, 4'd4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      issue(($urandom_range(0, 3) == 0) ? 7'($urandom) : SLAVE_ADDR,
            {$urandom, $urandom}, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
    end
    check("pending_expectations", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
